// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch slice.
//   XLEN         - address / instruction width
//   INSTR_BYTES  - PC increment per fetched instruction
//   QDEPTH       - depth of the fetched-instruction queue
//   QCNT_W       - width of the queue occupancy counter (holds 0..QDEPTH)
//   fetch_state_e, fetch_entry_t, pc_incr()
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned QDEPTH      = 2;
  localparam int unsigned QCNT_W      = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Wraps modulo 2^XLEN by construction.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory and decode-side handshakes of the fetch unit.
//   imemReq/imemAddr       fetch -> memory  request valid, byte address
//   imemReady              memory -> fetch  request accepted this cycle
//   imemRspValid/RspData   memory -> fetch  fetched word
//   instrValid/Data/PC     fetch -> decode  queue head
//   instrReady             decode -> fetch  head consumed this cycle
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if
  import fetch_pkg::*;
;
  logic            imemReq;
  logic [XLEN-1:0] imemAddr;
  logic            imemReady;
  logic            imemRspValid;
  logic [XLEN-1:0] imemRspData;
  logic            instrValid;
  logic [XLEN-1:0] instrData;
  logic [XLEN-1:0] instrPC;
  logic            instrReady;

  modport master (
    output imemReq, imemAddr,
    input  imemReady, imemRspValid, imemRspData,
    output instrValid, instrData, instrPC,
    input  instrReady
  );

  modport slave (
    input  imemReq, imemAddr,
    output imemReady, imemRspValid, imemRspData,
    input  instrValid, instrData, instrPC,
    output instrReady
  );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: small FIFO of fetched {pc, instr} entries.
//   clk, reset     clock, synchronous active-low reset
//   push/push_entry  write an entry (ignored when full unless popping too)
//   pop            remove the head (ignored when empty)
//   clear          drop all entries; wins over push and pop
//   head           current head entry
//   full/empty/count occupancy
module fetch_queue
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  fetch_entry_t      push_entry,
  input  logic              pop,
  input  logic              clear,
  output fetch_entry_t      head,
  output logic              full,
  output logic              empty,
  output logic [QCNT_W-1:0] count
);

  // QDEPTH is a power of two, so pointers wrap by plain overflow.
  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  fetch_entry_t      mem_q [QDEPTH];
  fetch_entry_t      mem_d [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [QCNT_W-1:0] count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == QCNT_W'(QDEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + QCNT_W'(1);
        2'b01:   count_d = count_q - QCNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a 2-entry queue.
//   clk, reset      clock, synchronous active-low reset
//   pcIN / nextPC   PC register output / next value (PC register loads every cycle)
//   flush/flushPC   redirect request and target
//   bus             fetch_unit_if.master (imem request/response, decode handshake)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | one cycle after reset release, nothing issued
// S_REQ     | may issue a request when the queue has room
// S_WAIT    | request accepted, waiting for its response
// S_DISCARD | flushed while waiting; the pending response is thrown away
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pcIN,
  output logic [XLEN-1:0] nextPC,
  input  logic            flush,
  input  logic [XLEN-1:0] flushPC,
  fetch_unit_if.master    bus
);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic [XLEN-1:0]   next_pc_raw;
  logic              req_raw;
  logic              outstanding;
  logic              credit_ok;

  logic              q_push, q_pop, q_clear, q_full, q_empty;
  logic [QCNT_W-1:0] q_count;
  fetch_entry_t      q_head, q_push_entry;

  // Queue slots already taken plus the one a pending response will need.
  assign outstanding  = (state_q == S_WAIT) || (state_q == S_DISCARD);
  assign credit_ok    = (32'(q_count) + 32'(outstanding)) < QDEPTH;
  assign q_pop        = bus.instrValid && bus.instrReady;
  assign q_push_entry = '{pc: req_pc_q, instr: bus.imemRspData};

  always_comb begin
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    next_pc_raw = pcIN;
    req_raw     = 1'b0;
    q_push      = 1'b0;
    q_clear     = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        req_raw = credit_ok && !flush;
        if (req_raw && bus.imemReady) begin
          next_pc_raw = pc_incr(pcIN);
          req_pc_d    = pcIN;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imemRspValid) begin
          // A response coinciding with a flush belongs to the old path.
          q_push  = !flush && !q_full;
          state_d = S_REQ;
        end else if (flush) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (bus.imemRspValid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Redirect overrides everything; in S_DISCARD the queue is already empty.
    if (flush) begin
      next_pc_raw = flushPC;
      q_clear     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Outputs are forced to their idle values for as long as reset is held,
  // not only after the first reset edge.
  assign nextPC         = reset ? next_pc_raw : RESET_PC;
  assign bus.imemReq    = reset && req_raw;
  assign bus.imemAddr   = (reset && req_raw) ? pcIN : '0;
  assign bus.instrValid = reset && !q_empty;
  assign bus.instrData  = reset ? q_head.instr : '0;
  assign bus.instrPC    = reset ? q_head.pc : '0;

  fetch_queue u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (q_push),
    .push_entry (q_push_entry),
    .pop        (q_pop),
    .clear      (q_clear),
    .head       (q_head),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. The bench plays the PC
// register, the instruction memory and the decode stage.
module tb_fetch_unit;
  import fetch_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcIN;
  logic [31:0] nextPC;
  logic        flush;
  logic [31:0] flushPC;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk     (clk),
    .reset   (reset),
    .pcIN    (pcIN),
    .nextPC  (nextPC),
    .flush   (flush),
    .flushPC (flushPC),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] s_nextPC, s_pcIN, s_addr, s_idata, s_ipc;
  logic        s_req, s_ivalid, s_rspv, s_accept;
  int          acc_cnt;

  bit          mem_pend;
  int          mem_timer;
  int          mem_lat;
  logic [31:0] mem_addr;

  ent_t exp_q[$];
  ent_t got_q[$];
  ent_t want_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 + (a << 8);
  endfunction

  // One clock of environment: sample at negedge, then update PC register
  // and memory response just after the rising edge.
  task automatic tick();
    @(negedge clk);
    s_nextPC = nextPC;
    s_pcIN   = pcIN;
    s_req    = bus.imemReq;
    s_addr   = bus.imemAddr;
    s_ivalid = bus.instrValid;
    s_idata  = bus.instrData;
    s_ipc    = bus.instrPC;
    s_rspv   = bus.imemRspValid;
    s_accept = bus.imemReq && bus.imemReady;
    if (bus.instrValid && bus.instrReady) begin
      got_q.push_back(ent_t'({bus.instrPC, bus.instrData}));
      if (exp_q.size() > 0) want_q.push_back(exp_q.pop_front());
      else want_q.push_back(ent_t'(~{bus.instrPC, bus.instrData}));
    end
    if (flush || !reset) exp_q.delete();
    if (s_accept) begin
      exp_q.push_back(ent_t'({bus.imemAddr, mem_word(bus.imemAddr)}));
      acc_cnt++;
      mem_pend  = 1'b1;
      mem_timer = mem_lat;
      mem_addr  = bus.imemAddr;
    end
    @(posedge clk);
    #1;
    pcIN             = s_nextPC;
    bus.imemRspValid = 1'b0;
    bus.imemRspData  = '0;
    if (mem_pend) begin
      mem_timer--;
      if (mem_timer <= 0) begin
        bus.imemRspValid = 1'b1;
        bus.imemRspData  = mem_word(mem_addr);
        mem_pend         = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset            = 1'b0;
    flush            = 1'b0;
    flushPC          = '0;
    bus.imemReady    = 1'b1;
    bus.instrReady   = 1'b0;
    bus.imemRspValid = 1'b0;
    bus.imemRspData  = '0;
    mem_pend         = 1'b0;
    mem_lat          = 1;
    repeat (2) tick();
    reset = 1'b1;
    exp_q.delete();
    got_q.delete();
    want_q.delete();
    acc_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; flushPC = '0;
    pcIN = 32'h1234_5678;
    bus.imemReady = 1'b1; bus.instrReady = 1'b1;
    bus.imemRspValid = 1'b0; bus.imemRspData = '0;
    mem_pend = 1'b0; mem_lat = 1; acc_cnt = 0;
    tick();
    checks++; if (s_nextPC !== 32'h0) begin errors++; $display("FAIL rst_nextPC got %h want %h", s_nextPC, 32'h0); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rst_imemReq got %b want 0", s_req); end
    checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL rst_imemAddr got %h want 0", s_addr); end
    checks++; if (s_ivalid !== 1'b0) begin errors++; $display("FAIL rst_instrValid got %b want 0", s_ivalid); end
    checks++; if ({s_idata, s_ipc} !== 64'h0) begin errors++; $display("FAIL rst_instr got %h/%h want 0/0", s_idata, s_ipc); end
    tick();
    reset = 1'b1;
    pcIN  = 32'h0000_0040;
    tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL idle_imemReq got %b want 0", s_req); end
    checks++; if (s_nextPC !== 32'h40) begin errors++; $display("FAIL idle_nextPC got %h want %h", s_nextPC, 32'h40); end
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h40) begin errors++; $display("FAIL first_req got %b/%h want 1/%h", s_req, s_addr, 32'h40); end
    checks++; if (s_nextPC !== 32'h44) begin errors++; $display("FAIL first_nextPC got %h want %h", s_nextPC, 32'h44); end
  endtask

  task automatic test_basic();
    int n;
    ent_t g, w;
    do_reset();
    mem_lat = 2;
    tick();
    tick();
    checks++; if (s_accept !== 1'b1 || s_addr !== 32'h0) begin errors++; $display("FAIL basic_accept got %b/%h want 1/0", s_accept, s_addr); end
    checks++; if (s_nextPC !== 32'h4) begin errors++; $display("FAIL basic_nextPC got %h want 4", s_nextPC); end
    n = 0;
    do begin tick(); n++; end while (!s_ivalid && n < 10);
    checks++; if (n !== 3) begin errors++; $display("FAIL basic_latency got %0d want 3", n); end
    checks++; if (s_ipc !== 32'h0 || s_idata !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr got %h/%h want 0/00500093", s_ipc, s_idata); end
    bus.instrReady = 1'b1;
    repeat (6) tick();
    checks++; if (got_q.size() < 2) begin errors++; $display("FAIL basic_popcount got %0d want >=2", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front(); checks++;
      if (g !== w) begin errors++; $display("FAIL basic_sb got %h want %h", g, w); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit seen;
    ent_t g, w;
    do_reset();
    mem_lat = 1;
    n = 0;
    while (acc_cnt < 2 && n < 20) begin tick(); n++; end
    checks++; if (acc_cnt < 2) begin errors++; $display("FAIL bp_fill accepts got %0d want 2", acc_cnt); end
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL bp_hold_req cyc %0d got %b want 0", i, s_req); end
      checks++; if (s_nextPC !== 32'h8) begin errors++; $display("FAIL bp_hold_pc cyc %0d got %h want 8", i, s_nextPC); end
      checks++; if (s_ivalid !== 1'b1 || s_ipc !== 32'h0) begin errors++; $display("FAIL bp_head cyc %0d got %b/%h want 1/0", i, s_ivalid, s_ipc); end
    end
    checks++; if (acc_cnt !== 2) begin errors++; $display("FAIL bp_accepts got %0d want 2", acc_cnt); end
    bus.instrReady = 1'b1;
    n = 0; seen = 0;
    while (acc_cnt < 4 && n < 20) begin
      tick(); n++;
      if (s_accept && !seen) begin
        seen = 1;
        checks++; if (s_addr !== 32'h8) begin errors++; $display("FAIL bp_resume_addr got %h want 8", s_addr); end
      end
    end
    checks++; if (acc_cnt < 4) begin errors++; $display("FAIL bp_resume accepts got %0d want 4", acc_cnt); end
    bus.imemReady = 1'b0;
    repeat (6) tick();
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front(); checks++;
      if (g !== w) begin errors++; $display("FAIL bp_sb got %h want %h", g, w); end
    end
  endtask

  task automatic test_flush_wait();
    int n;
    ent_t g, w;
    do_reset();
    mem_lat = 2;
    n = 0;
    while (acc_cnt < 2 && n < 20) begin tick(); n++; end
    checks++; if (acc_cnt < 2) begin errors++; $display("FAIL fl_setup accepts got %0d want 2", acc_cnt); end
    flush = 1'b1; flushPC = 32'h0000_0100;
    tick();
    flush = 1'b0;
    checks++; if (s_nextPC !== 32'h100 || s_req !== 1'b0) begin errors++; $display("FAIL fl_cycle got %h/%b want 100/0", s_nextPC, s_req); end
    tick();
    checks++; if (s_rspv !== 1'b1 || s_ivalid !== 1'b0) begin errors++; $display("FAIL fl_drop rsp/valid got %b/%b want 1/0", s_rspv, s_ivalid); end
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin errors++; $display("FAIL fl_next_addr got %b/%h want 1/100", s_req, s_addr); end
    checks++; if (s_ivalid !== 1'b0) begin errors++; $display("FAIL fl_empty got %b want 0", s_ivalid); end
    bus.instrReady = 1'b1;
    repeat (8) tick();
    checks++; if (got_q.size() == 0 || got_q[0].pc !== 32'h100) begin errors++; $display("FAIL fl_first_pop got %0d entries want head pc 100", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front(); checks++;
      if (g !== w) begin errors++; $display("FAIL fl_sb got %h want %h", g, w); end
    end
  endtask

  task automatic test_wrap();
    ent_t g, w;
    do_reset();
    flush = 1'b1; flushPC = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    checks++; if (s_nextPC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_flush_idle got %h want fffffffc", s_nextPC); end
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got %b/%h want 1/fffffffc", s_req, s_addr); end
    checks++; if (s_nextPC !== 32'h0) begin errors++; $display("FAIL wrap_nextPC got %h want 0", s_nextPC); end
    bus.instrReady = 1'b1;
    repeat (6) tick();
    checks++; if (got_q.size() == 0 || got_q[0].pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first_pop got %0d entries want head pc fffffffc", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front(); checks++;
      if (g !== w) begin errors++; $display("FAIL wrap_sb got %h want %h", g, w); end
    end
  endtask

  task automatic test_push_pop();
    int n;
    ent_t g, w;
    do_reset();
    mem_lat = 1;
    n = 0;
    while (acc_cnt < 2 && n < 20) begin tick(); n++; end
    bus.instrReady = 1'b1;
    tick();
    checks++; if (s_rspv !== 1'b1 || s_ivalid !== 1'b1 || s_ipc !== 32'h0) begin errors++; $display("FAIL pp_same_cycle rsp/valid/pc got %b/%b/%h want 1/1/0", s_rspv, s_ivalid, s_ipc); end
    bus.instrReady = 1'b0;
    tick();
    checks++; if (s_ivalid !== 1'b1 || s_ipc !== 32'h4 || s_idata !== mem_word(32'h4)) begin errors++; $display("FAIL pp_head got %b/%h/%h want 1/4/%h", s_ivalid, s_ipc, s_idata, mem_word(32'h4)); end
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL pp_count_one req got %b want 1", s_req); end
    tick(); tick();
    checks++; if (s_req !== 1'b0 || s_ipc !== 32'h4) begin errors++; $display("FAIL pp_full req/pc got %b/%h want 0/4", s_req, s_ipc); end
    bus.instrReady = 1'b1;
    repeat (6) tick();
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front(); checks++;
      if (g !== w) begin errors++; $display("FAIL pp_sb got %h want %h", g, w); end
    end
  endtask

  task automatic test_reset_wait();
    int n;
    bit late;
    ent_t g, w;
    do_reset();
    mem_lat = 1;
    n = 0;
    while (acc_cnt < 1 && n < 20) begin tick(); n++; end
    mem_lat = 3;
    n = 0;
    while (acc_cnt < 2 && n < 20) begin tick(); n++; end
    checks++; if (acc_cnt < 2) begin errors++; $display("FAIL rw_setup accepts got %0d want 2", acc_cnt); end
    reset = 1'b0;
    tick();
    checks++; if (s_nextPC !== 32'h0 || s_req !== 1'b0 || s_ivalid !== 1'b0) begin errors++; $display("FAIL rw_during nextPC/req/valid got %h/%b/%b want 0/0/0", s_nextPC, s_req, s_ivalid); end
    reset = 1'b1;
    bus.imemReady = 1'b0;
    tick();
    checks++; if (s_ivalid !== 1'b0 || s_idata !== 32'h0 || s_ipc !== 32'h0) begin errors++; $display("FAIL rw_after_q got %b/%h/%h want 0/0/0", s_ivalid, s_idata, s_ipc); end
    checks++; if (s_req !== 1'b0 || s_addr !== 32'h0 || s_nextPC !== 32'h0) begin errors++; $display("FAIL rw_after_pc got %b/%h/%h want 0/0/0", s_req, s_addr, s_nextPC); end
    late = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s_rspv) late = 1;
      checks++; if (s_ivalid !== 1'b0) begin errors++; $display("FAIL rw_late_ignored cyc %0d got %b want 0", i, s_ivalid); end
    end
    checks++; if (!late) begin errors++; $display("FAIL rw_late_rsp seen got 0 want 1"); end
    bus.imemReady = 1'b1; bus.instrReady = 1'b1;
    mem_lat = 1;
    repeat (8) tick();
    checks++; if (got_q.size() == 0 || got_q[0].pc !== 32'h0) begin errors++; $display("FAIL rw_restart got %0d entries want head pc 0", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front(); checks++;
      if (g !== w) begin errors++; $display("FAIL rw_sb got %h want %h", g, w); end
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    ent_t g, w;
    do_reset();
    exp_addr = 32'h0;
    for (int i = 0; i < 80; i++) begin
      bus.instrReady = ($urandom_range(0, 3) != 0);
      bus.imemReady  = ($urandom_range(0, 2) != 0);
      mem_lat        = $urandom_range(1, 3);
      tick();
      if (s_accept) begin
        checks++; if (s_addr !== exp_addr) begin errors++; $display("FAIL stream_addr got %h want %h", s_addr, exp_addr); end
        exp_addr = exp_addr + 32'h4;
      end
    end
    bus.imemReady = 1'b0; bus.instrReady = 1'b1;
    repeat (8) tick();
    checks++; if (got_q.size() < 8) begin errors++; $display("FAIL stream_pops got %0d want >=8", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front(); checks++;
      if (g !== w) begin errors++; $display("FAIL stream_sb got %h want %h", g, w); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_wait();
    test_wrap();
    test_push_pop();
    test_reset_wait();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, value driven on nextPC while reset is asserted.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-low reset; reset==0 at a rising edge SHALL reset the block.
REQ-004 pcIN  input  32  current PC value, taken from the PC register output.
REQ-005 nextPC  output  32  next PC value, fed back to the PC register input; the PC register loads it every cycle.
REQ-006 imemReq, imemAddr  output  1/32  instruction-memory request valid and byte address.
REQ-007 imemReady  input  1  memory accepts the request this cycle.
REQ-008 imemRspValid, imemRspData  input  1/32  fetched-word response, one per accepted request, arriving 1 or more cycles after acceptance.
REQ-009 instrValid, instrData, instrPC  output  1/32/32  queue-head instruction and its address, toward decode.
REQ-010 instrReady  input  1  decode consumes the head this cycle.
REQ-011 flush, flushPC  input  1/32  redirect request and target (branch/jump).

Function
REQ-012 FSM states: S_IDLE, S_REQ, S_WAIT, S_DISCARD; the block SHALL allow at most one outstanding memory request.
REQ-013 S_IDLE: the first cycle after reset release SHALL move to S_REQ; imemReq=0; nextPC=pcIN.
REQ-014 S_REQ: imemReq=1 and imemAddr=pcIN only when queue count plus outstanding is less than 2 and flush=0; otherwise imemReq=0.
REQ-015 Request handshake (imemReq&imemReady): nextPC=pcIN+4 (mod 2^32, so 32'hFFFFFFFC wraps to 0); pcIN is latched as reqPC; the FSM moves to S_WAIT.
REQ-016 Without handshake, nextPC=pcIN (PC holds).
REQ-017 S_WAIT: on imemRspValid, the block SHALL push {reqPC, imemRspData} into the queue and return to S_REQ; no new request SHALL be issued in that same cycle.
REQ-018 Queue: 2-entry FIFO; instrValid=(count!=0); pop on instrValid&instrReady; simultaneous push and pop SHALL keep count unchanged, with FIFO order preserved.
REQ-019 Flush has priority over every other event: nextPC=flushPC, queue cleared (instrValid=0 next cycle), imemReq forced to 0 that cycle.
REQ-020 Flush in S_WAIT with imemRspValid=0 SHALL move the FSM to S_DISCARD; flush in S_WAIT with imemRspValid=1 SHALL drop that response and move to S_REQ.
REQ-021 S_DISCARD: the next imemRspValid SHALL be dropped (no push) and the FSM SHALL move to S_REQ; a flush while in S_DISCARD SHALL update nextPC only.
REQ-022 Flush in S_REQ or S_IDLE: the FSM SHALL stay in, or move to, S_REQ.
REQ-023 Any imemRspValid that arrives in S_IDLE or S_REQ SHALL be ignored.

Reset
REQ-024 While reset==0: nextPC=RESET_PC, imemReq=0, imemAddr=0, instrValid=0, instrData=0, instrPC=0, queue count=0, state=S_IDLE.
REQ-025 Reset asserted mid-request SHALL abandon the outstanding request; any response arriving after reset release SHALL be ignored under REQ-023.

Structure
REQ-026 Package fetch_pkg SHALL hold the state encoding (2 bits), INSTR_BYTES=4 and QDEPTH=2.
REQ-027 The 2-entry queue SHALL be the sub-module fetch_queue (push, pop, clear, full, empty, count), instantiated once.
REQ-028 The FSM, handshake and nextPC logic SHALL reside in fetch_unit.

Verification
REQ-029 Reset release, pcIN=0, imemReady=1, response 2 cycles later with 32'h00500093 -> imemAddr=0, nextPC=4 in the accept cycle; instrValid=1, instrPC=0, instrData=32'h00500093.
REQ-030 instrReady=0 held for 4 fetches -> after 2 entries are queued, imemReq stays 0 and nextPC==pcIN; releasing instrReady resumes requests.
REQ-031 Flush (flushPC=32'h00000100) in S_WAIT, response on the following cycle -> response dropped, queue empty, next imemAddr=32'h00000100.
REQ-032 pcIN=32'hFFFFFFFC accepted -> nextPC=32'h00000000.
REQ-033 Push and pop in the same cycle with count=1 -> count stays 1, order preserved.
REQ-034 Reset asserted while in S_WAIT -> all outputs at reset values next cycle; a late response after release creates no queue entry.
